// File: rtl/eth_udp_loopback.sv
// RGMII self-test: sends a fixed UDP/IPv4 frame one nibble per clock (auto + key) and checks looped-back frames.
// TX nibbles are registered; the RX verdict lands on led one clock after rxctl is sampled low; there is no backpressure.
module eth_udp_loopback #(
  parameter logic [47:0] SRC_MAC     = 48'h00_11_22_33_44_55,
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0166,
  parameter logic [15:0] SRC_PORT    = 16'd1234,
  parameter logic [15:0] DST_PORT    = 16'd1234,
  parameter int          PAYLOAD_LEN = 32,
  parameter int          START_DELAY = 16,
  parameter int          PERIOD      = 1024
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       rgmii_eth_txc,
  output logic       rgmii_eth_txctl,
  output logic [3:0] rgmii_eth_txd,
  input  logic       rgmii_eth_rxc,
  input  logic       rgmii_eth_rxctl,
  input  logic [3:0] rgmii_eth_rxd,
  output logic [1:0] led
);
  localparam int HDR_BYTES  = 42;
  localparam int DATA_BYTES = HDR_BYTES + PAYLOAD_LEN;
  localparam logic [15:0] HDR_B    = 16'(HDR_BYTES);
  localparam logic [15:0] HDR_END  = 16'(16 + 2 * HDR_BYTES);
  localparam logic [15:0] DATA_END = 16'(16 + 2 * DATA_BYTES);
  localparam logic [15:0] FRAME_N  = 16'(16 + 2 * DATA_BYTES + 8);
  localparam logic [15:0] RX_BYTES = 16'(DATA_BYTES + 4);
  localparam logic [15:0] IP_LEN   = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN  = 16'(8 + PAYLOAD_LEN);

  function automatic logic [15:0] ip_csum(input logic [15:0] len, input logic [31:0] sip,
                                          input logic [31:0] dip);
    logic [31:0] s;
    s = 32'h0000_4500 + {16'h0, len} + 32'h0000_4000 + 32'h0000_4011
      + {16'h0, sip[31:16]} + {16'h0, sip[15:0]} + {16'h0, dip[31:16]} + {16'h0, dip[15:0]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  localparam logic [15:0] IP_CSUM = ip_csum(IP_LEN, SRC_IP, DST_IP);
  localparam logic [HDR_BYTES*8-1:0] HDR = {DST_MAC, SRC_MAC, 16'h0800,
    16'h4500, IP_LEN, 16'h0000, 16'h4000, 16'h4011, IP_CSUM, SRC_IP, DST_IP,
    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] data_byte(input logic [15:0] b);
    logic [7:0] r;
    int idx;
    idx = 8 * (HDR_BYTES - 1 - int'(b));
    if (b < HDR_B) r = HDR[idx +: 8];
    else           r = b[7:0] - HDR_B[7:0];
    return r;
  endfunction

  function automatic logic [3:0] tx_nibble(input logic [15:0] n, input logic [31:0] crc);
    logic [15:0] d;
    logic [7:0]  b;
    logic [2:0]  k;
    logic [31:0] sh;
    logic [3:0]  r;
    d  = n - 16'd16;
    b  = data_byte(d >> 1);
    k  = 3'(n - DATA_END);
    sh = (~crc) >> {k, 2'b00};
    if (n < 16'd16)          r = (n == 16'd15) ? 4'hD : 4'h5;
    else if (n < DATA_END)   r = d[0] ? b[7:4] : b[3:0];
    else                     r = sh[3:0];
    return r;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_PRE, TX_HDR, TX_PAY, TX_FCS, TX_IFG} tx_state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_PRE, RX_DATA, RX_END} rx_state_t;

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] nib_q, nib_d, nxt, dn;
  logic [31:0] tx_crc_q, tx_crc_d;
  logic        txctl_q, txctl_d;
  logic [3:0]  txd_q, txd_d;
  logic [15:0] auto_q, auto_d;
  logic        pend_q, pend_d;
  logic [2:0]  key_q, key_d;
  logic        auto_fire, key_rise, trig;

  rx_state_t   rx_state_q, rx_state_d;
  logic [3:0]  rx_lo_q, rx_lo_d;
  logic [15:0] rx_nib_q, rx_nib_d, rx_byte_q, rx_byte_d;
  logic [31:0] rx_crc_q, rx_crc_d;
  logic [1:0]  led_q, led_d;
  logic        rx_good;
  logic        unused_rxc;

  assign unused_rxc      = rgmii_eth_rxc;
  assign rgmii_eth_txc   = sys_clk;
  assign rgmii_eth_txctl = txctl_q;
  assign rgmii_eth_txd   = txd_q;
  assign led             = led_q;

  always_comb begin
    auto_fire  = (auto_q == 16'd0);
    auto_d     = auto_fire ? 16'(PERIOD - 1) : auto_q - 16'd1;
    key_d      = {key_q[1:0], key_in};
    key_rise   = key_q[1] & ~key_q[2];
    trig       = pend_q | auto_fire | key_rise;
    pend_d     = trig;
    tx_state_d = tx_state_q;
    nib_d      = nib_q;
    tx_crc_d   = tx_crc_q;
    txctl_d    = txctl_q;
    txd_d      = txd_q;
    nxt        = nib_q + 16'd1;
    dn         = nxt - 16'd16;
    case (tx_state_q)
      TX_IDLE: if (trig) begin
        tx_state_d = TX_PRE;
        nib_d      = 16'd0;
        txctl_d    = 1'b1;
        txd_d      = 4'h5;
        tx_crc_d   = 32'hFFFF_FFFF;
        pend_d     = 1'b0;
      end
      TX_PRE, TX_HDR, TX_PAY, TX_FCS: begin
        nib_d = nxt;
        if (nxt == FRAME_N) begin
          tx_state_d = TX_IFG;
          nib_d      = 16'd0;
          txctl_d    = 1'b0;
          txd_d      = 4'h0;
        end else begin
          txd_d = tx_nibble(nxt, tx_crc_q);
          // Fold each byte into the FCS as its high nibble goes out.
          if (nxt >= 16'd16 && nxt < DATA_END && dn[0])
            tx_crc_d = crc_byte(tx_crc_q, data_byte(dn >> 1));
          if (nxt < 16'd16)        tx_state_d = TX_PRE;
          else if (nxt < HDR_END)  tx_state_d = TX_HDR;
          else if (nxt < DATA_END) tx_state_d = TX_PAY;
          else                     tx_state_d = TX_FCS;
        end
      end
      TX_IFG: begin
        nib_d = nxt;
        if (nib_q == 16'd23) begin
          tx_state_d = TX_IDLE;
          nib_d      = 16'd0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Residue of the reflected register; bit-reversed it is 0xC704DD7B.
  assign rx_good = (rx_byte_q == RX_BYTES) && !rx_nib_q[0] && (rx_crc_q == 32'hDEBB_20E3);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_lo_d    = rx_lo_q;
    rx_nib_d   = rx_nib_q;
    rx_byte_d  = rx_byte_q;
    rx_crc_d   = rx_crc_q;
    led_d      = led_q;
    case (rx_state_q)
      RX_HUNT: if (rgmii_eth_rxctl && rgmii_eth_rxd == 4'h5) rx_state_d = RX_PRE;
      RX_PRE: begin
        if (!rgmii_eth_rxctl) rx_state_d = RX_HUNT;
        else if (rgmii_eth_rxd == 4'hD) begin
          rx_state_d = RX_DATA;
          rx_nib_d   = 16'd0;
          rx_byte_d  = 16'd0;
          rx_crc_d   = 32'hFFFF_FFFF;
        end else if (rgmii_eth_rxd != 4'h5) rx_state_d = RX_HUNT;
      end
      RX_DATA: begin
        if (!rgmii_eth_rxctl) rx_state_d = RX_END;
        else begin
          rx_nib_d = rx_nib_q + 16'd1;
          if (!rx_nib_q[0]) rx_lo_d = rgmii_eth_rxd;
          else begin
            rx_crc_d  = crc_byte(rx_crc_q, {rgmii_eth_rxd, rx_lo_q});
            rx_byte_d = rx_byte_q + 16'd1;
          end
        end
      end
      RX_END: begin
        rx_state_d = RX_HUNT;
        if (rx_good) led_d[0] = 1'b1;
        else         led_d[1] = 1'b1;
      end
      default: rx_state_d = RX_HUNT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= TX_IDLE;
      nib_q      <= 16'd0;
      tx_crc_q   <= 32'h0;
      txctl_q    <= 1'b0;
      txd_q      <= 4'h0;
      auto_q     <= 16'(START_DELAY);
      pend_q     <= 1'b0;
      key_q      <= 3'b000;
      rx_state_q <= RX_HUNT;
      rx_lo_q    <= 4'h0;
      rx_nib_q   <= 16'd0;
      rx_byte_q  <= 16'd0;
      rx_crc_q   <= 32'h0;
      led_q      <= 2'b00;
    end else begin
      tx_state_q <= tx_state_d;
      nib_q      <= nib_d;
      tx_crc_q   <= tx_crc_d;
      txctl_q    <= txctl_d;
      txd_q      <= txd_d;
      auto_q     <= auto_d;
      pend_q     <= pend_d;
      key_q      <= key_d;
      rx_state_q <= rx_state_d;
      rx_lo_q    <= rx_lo_d;
      rx_nib_q   <= rx_nib_d;
      rx_byte_q  <= rx_byte_d;
      rx_crc_q   <= rx_crc_d;
      led_q      <= led_d;
    end
  end
endmodule

// File: tb/tb_eth_udp_loopback.sv
// Bench for eth_udp_loopback: TX looped to RX through a 6 ns delay with optional corruption.
// Frame start windows are queued when stimulus is driven and popped as frames appear on TX.
module tb_eth_udp_loopback;
  localparam int PL   = 32;
  localparam int SD   = 16;
  localparam int PER  = 1024;
  localparam int DB   = 42 + PL;
  localparam int NB   = DB + 4;
  localparam int FNIB = 2 * (8 + 46 + PL);
  localparam logic [47:0] SMAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] DMAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] SIP  = 32'hC0A8_010A;
  localparam logic [31:0] DIP  = 32'hC0A8_0166;
  localparam logic [15:0] PORT = 16'd1234;

  typedef struct { int lo; int hi; } win_t;
  typedef struct { int flip; int trunc; logic [1:0] led; } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic       rgmii_eth_txc, rgmii_eth_txctl;
  logic [3:0] rgmii_eth_txd;
  logic       rgmii_eth_rxc = 1'b0;
  logic       rgmii_eth_rxctl = 1'b0;
  logic [3:0] rgmii_eth_rxd = 4'h0;
  logic [1:0] led;

  int total = 0, bad = 0;
  int cyc = 0, rel_cyc = 0;
  int lb_idx = 0, lb_flip = 0, lb_trunc = 0;
  int run = 0, mism = 0, frames_done = 0, frames_started = 0;
  bit fields_done = 0;
  win_t exp_start_q[$];
  win_t mon_w;
  logic [7:0] eb   [0:NB-1];
  logic [7:0] capb [0:NB-1];
  logic [3:0] exp_nib [0:FNIB-1];
  logic [3:0] cap [0:FNIB-1];
  vec_t vecs [6];

  eth_udp_loopback dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
    .rgmii_eth_txc(rgmii_eth_txc), .rgmii_eth_txctl(rgmii_eth_txctl), .rgmii_eth_txd(rgmii_eth_txd),
    .rgmii_eth_rxc(rgmii_eth_rxc), .rgmii_eth_rxctl(rgmii_eth_rxctl), .rgmii_eth_rxd(rgmii_eth_rxd),
    .led(led)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // External loopback: 6 ns wire delay, optional nibble flip or early rxctl drop.
  always @(posedge sys_clk) begin
    #6;
    if (rgmii_eth_txctl) lb_idx = lb_idx + 1;
    else lb_idx = 0;
    rgmii_eth_rxctl = rgmii_eth_txctl && !(lb_trunc > 0 && lb_idx > FNIB - lb_trunc);
    rgmii_eth_rxd   = rgmii_eth_txd ^ ((rgmii_eth_txctl && lb_idx == lb_flip) ? 4'h1 : 4'h0);
  end

  function automatic int rel_now();
    return cyc - rel_cyc;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] crc32_ref(input logic [7:0] b [0:NB-1], input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic build_model();
    logic [31:0] s, crc;
    logic [15:0] cs;
    for (int i = 0; i < 6; i++) begin
      eb[i]     = DMAC[47 - 8*i -: 8];
      eb[6 + i] = SMAC[47 - 8*i -: 8];
    end
    eb[12] = 8'h08; eb[13] = 8'h00;
    eb[14] = 8'h45; eb[15] = 8'h00; eb[16] = 8'h00; eb[17] = 8'(28 + PL);
    eb[18] = 8'h00; eb[19] = 8'h00; eb[20] = 8'h40; eb[21] = 8'h00;
    eb[22] = 8'h40; eb[23] = 8'h11; eb[24] = 8'h00; eb[25] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      eb[26 + i] = SIP[31 - 8*i -: 8];
      eb[30 + i] = DIP[31 - 8*i -: 8];
    end
    s = 0;
    for (int w = 0; w < 10; w++) s = s + {16'h0, eb[14 + 2*w], eb[15 + 2*w]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    eb[24] = cs[15:8]; eb[25] = cs[7:0];
    eb[34] = PORT[15:8]; eb[35] = PORT[7:0]; eb[36] = PORT[15:8]; eb[37] = PORT[7:0];
    eb[38] = 8'h00; eb[39] = 8'(8 + PL); eb[40] = 8'h00; eb[41] = 8'h00;
    for (int i = 0; i < PL; i++) eb[42 + i] = 8'(i);
    for (int i = DB; i < NB; i++) eb[i] = 8'h00;
    crc = crc32_ref(eb, DB);
    for (int k = 0; k < 4; k++) eb[DB + k] = crc[8*k +: 8];
    for (int i = 0; i < 16; i++) exp_nib[i] = (i == 15) ? 4'hD : 4'h5;
    for (int b = 0; b < NB; b++) begin
      exp_nib[16 + 2*b] = eb[b][3:0];
      exp_nib[17 + 2*b] = eb[b][7:4];
    end
  endtask

  task automatic check_fields();
    logic [31:0] s;
    logic [63:0] pre;
    pre = 0;
    for (int i = 0; i < 16; i++) pre[4*i +: 4] = cap[i];
    check("preamble+sfd", pre, 64'hD555_5555_5555_5555);
    for (int b = 0; b < NB; b++) capb[b] = {cap[17 + 2*b], cap[16 + 2*b]};
    check("ethertype", {capb[12], capb[13]}, 16'h0800);
    check("ip total len", {capb[16], capb[17]}, 16'h003C);
    s = 0;
    for (int w = 0; w < 10; w++) s = s + {16'h0, capb[14 + 2*w], capb[15 + 2*w]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    check("ip header sum", s, 32'h0000_FFFF);
    check("udp len", {capb[38], capb[39]}, 16'h0028);
    check("fcs", {capb[DB+3], capb[DB+2], capb[DB+1], capb[DB]}, crc32_ref(capb, DB));
  endtask

  // TX monitor: scoreboard pop on each frame start, nibble compare against the model.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) run = 0;
    else if (rgmii_eth_txctl) begin
      if (run == 0) begin
        frames_started++;
        mism = 0;
        if (exp_start_q.size() == 0) check_range("unexpected frame start", rel_now(), -1, -1);
        else begin
          mon_w = exp_start_q.pop_front();
          check_range("frame start", rel_now(), mon_w.lo, mon_w.hi);
        end
      end
      if (run < FNIB) begin
        cap[run] = rgmii_eth_txd;
        if (rgmii_eth_txd !== exp_nib[run]) mism++;
      end
      run++;
    end else if (run > 0) begin
      check("frame length", run, FNIB);
      check("frame nibble mismatches", mism, 0);
      if (!fields_done) begin
        check_fields();
        fields_done = 1;
      end
      frames_done++;
      run = 0;
    end
  end

  task automatic do_reset();
    win_t w;
    sys_rst_n = 1'b0;
    exp_start_q.delete();
    repeat (3) @(negedge sys_clk);
    check("reset txctl", rgmii_eth_txctl, 0);
    check("reset txd", rgmii_eth_txd, 0);
    check("reset led", led, 0);
    sys_rst_n = 1'b1;
    rel_cyc = cyc;
    w.lo = SD + 1; w.hi = SD + 1;
    exp_start_q.push_back(w);
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check(nm, frames_done >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w;
    int p, k, tgt;
    build_model();
    vecs[0] = '{flip: 0,   trunc: 0, led: 2'b01};
    vecs[1] = '{flip: 105, trunc: 0, led: 2'b10};
    vecs[2] = '{flip: 0,   trunc: 2, led: 2'b10};
    vecs[3] = '{flip: 0,   trunc: 1, led: 2'b10};
    vecs[4] = '{flip: 170, trunc: 0, led: 2'b10};
    vecs[5] = '{flip: 20,  trunc: 0, led: 2'b10};

    @(posedge sys_clk); #1;
    check("txc follows clk", rgmii_eth_txc, 1);

    for (int i = 0; i < 6; i++) begin
      lb_flip  = vecs[i].flip;
      lb_trunc = vecs[i].trunc;
      do_reset();
      tgt = frames_done + 1;
      wait_frames(tgt, 400, $sformatf("case%0d frame seen", i));
      repeat (10) @(negedge sys_clk);
      check($sformatf("case%0d led", i), led, vecs[i].led);
    end

    // Key request while idle, then the auto schedule must be unaffected.
    lb_flip = 0; lb_trunc = 0;
    do_reset();
    tgt = frames_done + 1;
    wait_frames(tgt, 400, "first frame seen");
    while (rel_now() < 300) @(negedge sys_clk);
    p = rel_now();
    w.lo = p + 1; w.hi = p + 4;
    exp_start_q.push_back(w);
    key_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    key_in = 1'b0;
    tgt = frames_done + 1;
    wait_frames(tgt, 300, "key frame seen");
    w.lo = SD + 1 + PER; w.hi = SD + 1 + PER;
    exp_start_q.push_back(w);
    tgt = frames_started + 1;
    k = 0;
    while (frames_started < tgt && k < 1200) begin
      @(negedge sys_clk);
      k++;
    end
    check("periodic frame started", frames_started >= tgt, 1);

    // Reset in the middle of that frame.
    repeat (50) @(negedge sys_clk);
    check("led before mid reset", led, 2'b01);
    check("txctl before mid reset", rgmii_eth_txctl, 1);
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check("mid reset txctl", rgmii_eth_txctl, 0);
    check("mid reset led", led, 0);
    do_reset();
    tgt = frames_done + 1;
    wait_frames(tgt, 400, "post reset frame seen");
    repeat (10) @(negedge sys_clk);
    check("post reset led", led, 2'b01);
    check("pending start windows", exp_start_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_udp_loopback.md
# eth_udp_loopback

Top-level Ethernet self-test block for the dual-OV5640 UDP board. It builds a fixed UDP/IPv4 test frame and transmits it nibble-serially on the RGMII TX pins, automatically and on key press. In parallel it receives frames on the RGMII RX pins, which are externally looped back in bring-up, and checks them by FCS and length. Everything runs in the sys_clk domain; the frame is sent single-data-rate, one nibble per clock.

## Interface
Parameters:
- SRC_MAC, 48'h00_11_22_33_44_55: source MAC address.
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF: destination MAC address.
- SRC_IP, 32'hC0A8_010A: source IP, 192.168.1.10.
- DST_IP, 32'hC0A8_0166: destination IP, 192.168.1.102.
- SRC_PORT / DST_PORT, 16'd1234: UDP ports.
- PAYLOAD_LEN, 32: payload bytes; must be at least 18.
- START_DELAY, 16: clocks from reset release to the first automatic frame.
- PERIOD, 1024: clocks between automatic frame starts; must be at least 200.

Ports:
- sys_clk  in  1: the only clock. One clock; all logic on the rising edge.
- sys_rst_n  in  1: asynchronous, active-low reset.
- key_in  in  1: active-high request for an extra frame.
- rgmii_eth_txc  out  1: forwarded copy of sys_clk.
- rgmii_eth_txctl  out  1: TX enable.
- rgmii_eth_txd  out  4: TX nibble.
- rgmii_eth_rxc  in  1: unused. It is not a clock in this block.
- rgmii_eth_rxctl  in  1: RX data valid, sampled on sys_clk.
- rgmii_eth_rxd  in  4: RX nibble, sampled on sys_clk.
- led  out  2: led[0] sticky "good frame received"; led[1] sticky "bad frame received".

## Operation
- Reset values: txctl=0, txd=0, led=0, TX FSM in IDLE, RX FSM in HUNT, all counters 0.
- Triggers:
  - Automatic: the first frame starts START_DELAY clocks after reset release, then one frame every PERIOD clocks.
  - Key: key_in passes through a 2-flop synchronizer; a synchronized rising edge sets a pending request. Pulses shorter than one clock may be missed.
  - A trigger during transmission stays pending and is served after the inter-frame gap. Multiple pending triggers collapse into one.
- Frame byte order:
  - Preamble: 7 bytes of 0x55, then SFD 0xD5.
  - DST_MAC, then SRC_MAC, then EtherType 0x0800.
  - IPv4 header: 45 00, total length (28+PAYLOAD_LEN), 00 00, 40 00, 40 11, header checksum, SRC_IP, DST_IP.
  - UDP header: SRC_PORT, DST_PORT, length (8+PAYLOAD_LEN), checksum 0000.
  - Payload: byte i = i[7:0].
  - FCS: 4 bytes.
- Multi-byte fields are sent MSB byte first. Each byte is sent low nibble first.
- IP header checksum: one's-complement of the one's-complement 16-bit sum of the header words, with the checksum field taken as 0. Compute it at elaboration or in registers before the frame starts.
- FCS: CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF). It covers destination MAC through the payload. It is sent LSB byte first.
- TX FSM: IDLE → PREAMBLE (16 nibbles) → HEADER (84 nibbles) → PAYLOAD → FCS (8 nibbles) → IFG (24 clocks, txctl=0) → IDLE.
- RX FSM:
  - HUNT: wait for rxctl=1 with nibble 5.
  - PREAMBLE: accept nibbles 5 until the SFD nibble pair 5 then D, then go to DATA. Any other nibble, or rxctl=0, returns to HUNT.
  - DATA: assemble bytes low nibble first and feed each completed byte to the RX CRC.
  - END: on the clock where rxctl falls, the frame is good only if all three hold: byte count = 46+PAYLOAD_LEN (including FCS), nibble count is even, and CRC residue = 0xC704DD7B. Good sets led[0]; anything else sets led[1]. Return to HUNT.
- Reset at any time aborts TX (txctl=0 on the next clock edge) and RX, and clears led.

## Timing
- txc = sys_clk, combinational.
- txd/txctl are registered; they change on the sys_clk rising edge.
- Frame length: 2×(8+46+PAYLOAD_LEN) nibble clocks. The default is 172 clocks with txctl=1.
- First automatic frame: txctl rises on the clock edge START_DELAY+1 clocks after reset release.
- The loopback path delay must be less than one clock period. A nibble driven at edge n is sampled at edge n+1.
- RX verdict: led updates 1 clock after the rxctl falling sample.

## Test plan
- Reset, then TX looped to RX with a 6 ns delay: txctl high for 172 consecutive clocks starting START_DELAY+1 clocks after reset release; first 16 nibbles are 5 repeated 15 times then D; led=2'b01 after the frame.
- Capture one default frame: IP checksum field is correct (the header sums to 0xFFFF); UDP length 0x0028; the FCS matches a reference CRC-32.
- key_in held high for 3 clocks while IDLE: a frame starts within 4 clocks; the next automatic frame still follows its PERIOD schedule.
- Flip one payload bit on the looped RX path: led[1]=1.
- Truncate the RX frame by 2 nibbles: led[1]=1.
- Assert reset mid-frame: txctl=0 and led=0 at the next clock edge; after release, the first automatic frame occurs START_DELAY+1 clocks later.
